pulse_train_generator: RTL and testbench
========================================

// Module: pulse_train_generator
// PURPOSE
//  Parametrised successor of the single-pulse impulse generator.
//  - Fetches a burst descriptor over the soc/eoc handshake: pulse width numero, gap pausa, count ripetizioni.
//  - Emits ripetizioni high pulses on out, each numero cycles wide, separated by pausa low cycles.
//  - Then returns to fetch the next descriptor.
//  - Sits between a descriptor producer (ADC-style soc/eoc peer) and timing/strobe consumers.
// PARAMETERS
//  W   8  width of numero, pausa and the internal cycle counter
//  RW  4  width of ripetizioni and the internal repetition counter
// PORTS
//  clock        in   1   system clock; all state changes on posedge
//  reset        in   1   synchronous reset, active-high
//  numero       in   W   pulse high width in cycles; valid while eoc=1
//  pausa        in   W   low gap between pulses in cycles; valid while eoc=1
//  ripetizioni  in   RW  number of pulses in the burst; valid while eoc=1
//  eoc          in   1   handshake from producer
//  stop         in   1   synchronous abort of the current burst
//  soc          out  1   handshake request to producer
//  out          out  1   generated pulse train
//  busy         out  1   1 while state is S_HIGH or S_LOW
//  done         out  1   one-cycle strobe on normal burst completion
// BEHAVIOUR
//  Reset, on posedge with reset=1:
//   - soc=0, out=0, done=0, cnt=0, rcnt=0, state=S_REQ.
//   - reset overrides stop and everything else, in any state including mid-burst.
//  All outputs are registered. done defaults to 0 every cycle unless set below.
//  S_REQ:
//   - soc<=1, out<=0.
//   - eoc=0 -> S_ACK; else stay.
//  S_ACK:
//   - soc<=0.
//   - Each cycle: latch numero->H, pausa->L, ripetizioni->rcnt.
//   - eoc=0: stay.
//   - eoc=1, numero=0 or ripetizioni=0: empty burst. done<=1, soc<=1, -> S_REQ; out stays 0.
//   - eoc=1, otherwise: out<=1, cnt<=numero, -> S_HIGH. The out rising edge is the edge that samples eoc=1.
//  S_HIGH (cnt counts H..1):
//   - cnt<=cnt-1.
//   - When cnt=1:
//     - rcnt=1: out<=0, done<=1, soc<=1, -> S_REQ.
//     - else L=0: rcnt<=rcnt-1, cnt<=H, stay. out stays 1, so pulses merge.
//     - else: out<=0, rcnt<=rcnt-1, cnt<=L, -> S_LOW.
//  S_LOW (cnt counts L..1):
//   - cnt<=cnt-1.
//   - When cnt=1: out<=1, cnt<=H, -> S_HIGH.
//  Timing results:
//   - out is high exactly H periods per pulse and low exactly L periods between pulses.
//   - No gap after the last pulse.
//   - soc rises on the same edge out falls for the last time.
//   - Maximum values H=2^W-1 and R=2^RW-1 are legal. No wrap: cnt never decrements below 1.
//  stop=1 in S_HIGH or S_LOW (checked before the rules above):
//   - out<=0, soc<=1, done stays 0, -> S_REQ.
//   - stop is ignored in S_REQ and S_ACK.
//  numero, pausa and ripetizioni are don't-care outside S_ACK. Changes mid-burst have no effect.
//  busy is combinational from state only (S_HIGH or S_LOW); all other outputs are registered.
// TESTING
//  1. Reset, then producer answers; eoc 1->0->1 with numero=3, pausa=2, ripetizioni=2
//     -> out = 1,1,1,0,0,1,1,1; done pulses once; soc=1 on the edge after the last high.
//  2. numero=5, ripetizioni=1, pausa=9 -> single 5-cycle pulse, no trailing gap, back to S_REQ.
//  3. numero=0, or ripetizioni=0 -> out never rises; done=1 for one cycle right after eoc=1; soc reasserted.
//  4. numero=2, pausa=0, ripetizioni=3 -> out continuously high for 6 cycles; done once.
//  5. stop=1 on the 2nd high cycle of numero=4 -> out=0 next edge, done=0, soc=1; next descriptor handled normally.
//  6. reset=1 asserted mid S_LOW -> next edge out=0, soc=0, busy=0; one edge later soc=1.
//     Also numero=255, ripetizioni=15, pausa=1 -> exactly 15 pulses of 255 cycles.

Source files
------------

// File: rtl/pulse_train_generator.sv
// -----------------------------------------------------------------------------
// pulse_train_generator
// Fetches a burst descriptor (pulse width, gap, repetition count) from an
// ADC-style soc/eoc producer, then emits the requested train of high pulses
// on `out`. Returns to fetch the next descriptor after the last pulse.
// A burst can be aborted with `stop`, and `reset` overrides everything.
// All outputs except `busy` are registered; `busy` decodes the state only.
// -----------------------------------------------------------------------------
module pulse_train_generator #(
    parameter int W  = 8,
    parameter int RW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  numero,
    input  logic [W-1:0]  pausa,
    input  logic [RW-1:0] ripetizioni,
    input  logic          eoc,
    input  logic          stop,
    output logic          soc,
    output logic          out,
    output logic          busy,
    output logic          done
);

    // State encoding kept as plain constants for compatibility with the
    // original single-pulse generator's tooling.
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam logic [W-1:0]  C_ZERO  = '0;
    localparam logic [W-1:0]  C_ONE   = W'(1);
    localparam logic [RW-1:0] R_ZERO  = '0;
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    // Architectural registers.
    logic [1:0]    r_state;
    logic          r_soc;
    logic          r_out;
    logic          r_done;
    logic [W-1:0]  r_cnt;     // cycles left in the current high or low phase
    logic [RW-1:0] r_rcnt;    // pulses left in the burst, including current
    logic [W-1:0]  r_high;    // latched pulse width
    logic [W-1:0]  r_low;     // latched gap width

    // Next-state values computed combinationally.
    logic [1:0]    w_state_nxt;
    logic          w_soc_nxt;
    logic          w_out_nxt;
    logic          w_done_nxt;
    logic [W-1:0]  w_cnt_nxt;
    logic [RW-1:0] w_rcnt_nxt;
    logic [W-1:0]  w_high_nxt;
    logic [W-1:0]  w_low_nxt;

    // Phase-end and burst-end conditions, shared by the transition logic.
    logic w_phase_last;
    logic w_burst_last;
    logic w_empty_desc;
    logic w_active;

    // Decode helper conditions from the current registers and inputs.
    always_comb begin
        w_phase_last = (r_cnt == C_ONE);
        w_burst_last = (r_rcnt == R_ONE);
        w_empty_desc = (numero == C_ZERO) || (ripetizioni == R_ZERO);
        w_active     = (r_state == S_HIGH) || (r_state == S_LOW);
    end

    // Compute the next state and the next value of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_soc_nxt   = r_soc;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_rcnt_nxt  = r_rcnt;
        w_high_nxt  = r_high;
        w_low_nxt   = r_low;

        case (r_state)
            S_REQ: begin
                // Request a descriptor and wait for the producer to drop eoc.
                w_soc_nxt = 1'b1;
                w_out_nxt = 1'b0;
                if (!eoc) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end

            S_ACK: begin
                // Descriptor fields are tracked every cycle so the values
                // present on the eoc=1 edge are the ones used.
                w_soc_nxt  = 1'b0;
                w_high_nxt = numero;
                w_low_nxt  = pausa;
                w_rcnt_nxt = ripetizioni;
                if (eoc) begin
                    if (w_empty_desc) begin
                        // Nothing to emit: complete immediately.
                        w_done_nxt  = 1'b1;
                        w_soc_nxt   = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        // First pulse rises on the very edge that sees eoc=1.
                        w_out_nxt   = 1'b1;
                        w_cnt_nxt   = numero;
                        w_state_nxt = S_HIGH;
                    end
                end else begin
                    w_state_nxt = S_ACK;
                end
            end

            S_HIGH: begin
                if (stop) begin
                    // Abort: drop the line and re-request without done.
                    w_out_nxt   = 1'b0;
                    w_soc_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                    if (w_phase_last) begin
                        if (w_burst_last) begin
                            // Last pulse ends: no trailing gap.
                            w_out_nxt   = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_soc_nxt   = 1'b1;
                            w_state_nxt = S_REQ;
                        end else if (r_low == C_ZERO) begin
                            // Zero gap: pulses merge into one continuous high.
                            w_rcnt_nxt  = r_rcnt - R_ONE;
                            w_cnt_nxt   = r_high;
                            w_state_nxt = S_HIGH;
                        end else begin
                            w_out_nxt   = 1'b0;
                            w_rcnt_nxt  = r_rcnt - R_ONE;
                            w_cnt_nxt   = r_low;
                            w_state_nxt = S_LOW;
                        end
                    end else begin
                        w_state_nxt = S_HIGH;
                    end
                end
            end

            S_LOW: begin
                if (stop) begin
                    w_out_nxt   = 1'b0;
                    w_soc_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                    if (w_phase_last) begin
                        // Gap over: start the next pulse.
                        w_out_nxt   = 1'b1;
                        w_cnt_nxt   = r_high;
                        w_state_nxt = S_HIGH;
                    end else begin
                        w_state_nxt = S_LOW;
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a quiet request state.
                w_state_nxt = S_REQ;
                w_soc_nxt   = 1'b0;
                w_out_nxt   = 1'b0;
                w_cnt_nxt   = C_ZERO;
                w_rcnt_nxt  = R_ZERO;
            end
        endcase
    end

    // Register state and outputs; reset has priority over every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_REQ;
            r_soc   <= 1'b0;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= C_ZERO;
            r_rcnt  <= R_ZERO;
            r_high  <= C_ZERO;
            r_low   <= C_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_soc   <= w_soc_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_high  <= w_high_nxt;
            r_low   <= w_low_nxt;
        end
    end

    // Drive ports: busy reflects the pulse-generating states only.
    always_comb begin
        soc  = r_soc;
        out  = r_out;
        done = r_done;
        busy = w_active;
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// -----------------------------------------------------------------------------
// Testbench for pulse_train_generator.
// Descriptors come from a table; for each one the expected per-cycle
// {out, done, busy, soc} sequence is derived from the pulse/gap/count
// definition and queued, then popped and compared cycle by cycle.
// Hand-written sequences cover reset, stop and reset-in-mid-burst.
// -----------------------------------------------------------------------------
module tb_pulse_train_generator;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] numero;
    logic [7:0] pausa;
    logic [3:0] ripetizioni;
    logic       eoc;
    logic       stop;
    logic       soc;
    logic       out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // expected {out, done, busy, soc} per cycle
    logic [3:0] sb_q[$];

    typedef struct {
        logic [7:0] n;
        logic [7:0] p;
        logic [3:0] r;
        int         exp_highs;
        int         exp_pulses;
    } vec_t;

    pulse_train_generator #(.W(8), .RW(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .numero      (numero),
        .pausa       (pausa),
        .ripetizioni (ripetizioni),
        .eoc         (eoc),
        .stop        (stop),
        .soc         (soc),
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) until the DUT requests a descriptor.
    task automatic wait_soc();
        int n;
        n = 0;
        while (soc !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("soc_request_timeout", {31'd0, soc}, 32'd1);
    endtask

    // Perform the producer side of the handshake; returns at the negedge
    // where eoc=1 is presented together with the descriptor.
    task automatic handshake(input logic [7:0] n, input logic [7:0] p, input logic [3:0] r);
        wait_soc();
        @(negedge clock);
        eoc = 1'b0;
        numero = 8'($urandom);
        @(negedge clock);
        @(negedge clock);
        numero = n;
        pausa = p;
        ripetizioni = r;
        eoc = 1'b1;
    endtask

    // Build the expected cycle sequence from the burst definition.
    task automatic push_expected(input logic [7:0] n, input logic [7:0] p, input logic [3:0] r);
        if (n != 8'd0 && r != 4'd0) begin
            for (int k = 0; k < int'(r); k++) begin
                for (int h = 0; h < int'(n); h++) sb_q.push_back(4'b1010);
                if (k < int'(r) - 1)
                    for (int g = 0; g < int'(p); g++) sb_q.push_back(4'b0010);
            end
        end
        sb_q.push_back(4'b0101);
        sb_q.push_back(4'b0001);
    endtask

    task automatic run_burst(input logic [7:0] n, input logic [7:0] p, input logic [3:0] r,
                             output int highs, output int pulses);
        logic       prev;
        logic [3:0] exp;
        int         idx;
        handshake(n, p, r);
        push_expected(n, p, r);
        highs = 0;
        pulses = 0;
        prev = 1'b0;
        idx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clock);
            // descriptor inputs are don't-care once the burst has started
            numero = 8'($urandom);
            pausa = 8'($urandom);
            ripetizioni = 4'($urandom);
            exp = sb_q.pop_front();
            check($sformatf("cycle_%0d_n%0d_p%0d_r%0d", idx, n, p, r),
                  {28'd0, out, done, busy, soc}, {28'd0, exp});
            if (out === 1'b1) highs++;
            if (out === 1'b1 && prev === 1'b0) pulses++;
            prev = out;
            idx++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int highs;
        int pulses;

        vecs[0] = '{n: 8'd3,   p: 8'd2, r: 4'd2,  exp_highs: 6,    exp_pulses: 2};
        vecs[1] = '{n: 8'd5,   p: 8'd9, r: 4'd1,  exp_highs: 5,    exp_pulses: 1};
        vecs[2] = '{n: 8'd0,   p: 8'd4, r: 4'd3,  exp_highs: 0,    exp_pulses: 0};
        vecs[3] = '{n: 8'd7,   p: 8'd1, r: 4'd0,  exp_highs: 0,    exp_pulses: 0};
        vecs[4] = '{n: 8'd2,   p: 8'd0, r: 4'd3,  exp_highs: 6,    exp_pulses: 1};
        vecs[5] = '{n: 8'd1,   p: 8'd1, r: 4'd4,  exp_highs: 4,    exp_pulses: 4};
        vecs[6] = '{n: 8'd255, p: 8'd1, r: 4'd15, exp_highs: 3825, exp_pulses: 15};
        vecs[7] = '{n: 8'd1,   p: 8'd0, r: 4'd1,  exp_highs: 1,    exp_pulses: 1};

        reset = 1'b1;
        eoc = 1'b1;
        stop = 1'b0;
        numero = 8'd0;
        pausa = 8'd0;
        ripetizioni = 4'd0;

        // reset state
        repeat (2) @(negedge clock);
        check("reset_outputs", {28'd0, out, done, busy, soc}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("soc_after_reset", {28'd0, out, done, busy, soc}, 32'b0001);

        // table-driven bursts
        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i].n, vecs[i].p, vecs[i].r, highs, pulses);
            check($sformatf("vec%0d_high_cycles", i), highs, vecs[i].exp_highs);
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
        end

        // stop on the second high cycle of a 4-wide pulse
        handshake(8'd4, 8'd2, 4'd3);
        @(negedge clock);
        check("stop_high1", {28'd0, out, done, busy, soc}, 32'b1010);
        @(negedge clock);
        check("stop_high2", {28'd0, out, done, busy, soc}, 32'b1010);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check("stop_abort", {28'd0, out, done, busy, soc}, 32'b0001);
        @(negedge clock);
        check("stop_no_done", {28'd0, out, done, busy, soc}, 32'b0001);
        run_burst(8'd2, 8'd1, 4'd2, highs, pulses);
        check("after_stop_highs", highs, 4);
        check("after_stop_pulses", pulses, 2);

        // stop is ignored while waiting for a descriptor
        stop = 1'b1;
        run_burst(8'd0, 8'd3, 4'd2, highs, pulses);
        stop = 1'b0;
        check("stop_in_req_highs", highs, 0);

        // reset in the middle of the low gap
        handshake(8'd3, 8'd4, 4'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("rst_pre_high%0d", c), {28'd0, out, done, busy, soc}, 32'b1010);
        end
        @(negedge clock);
        check("rst_pre_low", {28'd0, out, done, busy, soc}, 32'b0010);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_low", {28'd0, out, done, busy, soc}, 32'b0000);
        @(negedge clock);
        check("rst_soc_return", {28'd0, out, done, busy, soc}, 32'b0001);
        run_burst(8'd2, 8'd3, 4'd2, highs, pulses);
        check("after_rst_highs", highs, 4);
        check("after_rst_pulses", pulses, 2);

        check("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
